// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC stream packer.
// Holds the capture FSM state type, default widths and a popcount helper.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE,
    DRAIN
  } state_e;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DATA_W = 16;
  localparam int KEEP_W     = DEF_DATA_W / 8;

  function automatic logic [4:0] popcount(
    input logic [15:0] v
  );
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/adc_stream_packer_if.sv
// ADC frame input plus AXI4-Stream output bundle of the packer.
// master: packer side (sinks ADC frames, drives stream); slave: peer side.
interface adc_stream_packer_if
  import adc_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W
);

  logic                     adc_valid;
  logic [NUM_CH*DATA_W-1:0] adc_data;
  logic [DATA_W-1:0]        m_axis_tdata;
  logic [DATA_W/8-1:0]      m_axis_tkeep;
  logic                     m_axis_tlast;
  logic                     m_axis_tvalid;
  logic                     m_axis_tready;

  modport master (
    input  adc_valid,
    input  adc_data,
    input  m_axis_tready,
    output m_axis_tdata,
    output m_axis_tkeep,
    output m_axis_tlast,
    output m_axis_tvalid
  );

  modport slave (
    output adc_valid,
    output adc_data,
    output m_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tkeep,
    input  m_axis_tlast,
    input  m_axis_tvalid
  );

endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO, DEPTH a power of 2 (>= 2).
// Ports: clk, rst_n (sync, low), push_i/din_i, pop_i, full_o, empty_o, dout_o.
module sync_fifo_fwft #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] dout_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             wr_en;
  logic             rd_en;

  // Extra pointer bit separates full from empty.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign wr_en = push_i & ~full_o;
  assign rd_en = pop_i & ~empty_o;

  assign wr_d = wr_q + (AW+1)'(wr_en);
  assign rd_d = rd_q + (AW+1)'(rd_en);

  assign dout_o = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/adc_stream_packer.sv
// Captures masked ADC frames and emits them as one exact-length AXIS packet.
// Ports: adc_clk/adc_rst_n, sample_start/len/ch_mask in; st_clr/busy/
// overflow/sample_en out; bus = ADC frame input + AXIS master output.
module adc_stream_packer
  import adc_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 64,
  parameter int WAIT_CYCLES = 20,
  parameter int LEN_W       = 32
) (
  input  logic              adc_clk,
  input  logic              adc_rst_n,
  input  logic              sample_start,
  input  logic [LEN_W-1:0]  sample_len,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              st_clr,
  output logic              busy,
  output logic              overflow,
  output logic              sample_en,
  adc_stream_packer_if.master bus
);

  localparam int FW   = NUM_CH * DATA_W;
  localparam int WC_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WC_W-1:0] WLAST =
    WC_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e            state_q, state_d;
  logic              start_q;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [LEN_W-1:0]  frame_q, frame_d;
  logic [WC_W-1:0]   wait_q, wait_d;
  logic              ovf_q, ovf_d;
  logic              stclr_q, stclr_d;
  logic              ser_q, ser_d;
  logic [NUM_CH-1:0] rem_q, rem_d;
  logic [FW-1:0]     data_q, data_d;
  logic              lastf_q, lastf_d;

  logic              start_ok;
  logic              accept;
  logic              drop;
  logic              push;
  logic              pop;
  logic              done;
  logic [NUM_CH-1:0] rem_nxt;
  logic [LEN_W-1:0]  frame_nxt;
  logic [DATA_W-1:0] sel_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_dout;

  assign start_ok = sample_start & ~start_q &
                    (|sample_len) & (|ch_mask);

  assign accept = (state_q == SAMPLE) & bus.adc_valid & ~ser_q;
  assign drop   = (state_q == SAMPLE) & bus.adc_valid & ser_q;

  assign frame_nxt = frame_q + LEN_W'(1);

  // Serializer: lowest remaining enabled channel goes out first.
  assign rem_nxt = rem_q & (rem_q - NUM_CH'(1));
  assign push    = ser_q & ~fifo_full;

  always_comb begin
    sel_word = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rem_q[i]) begin
        sel_word = data_q[i*DATA_W +: DATA_W];
      end
    end
  end

  assign pop  = bus.m_axis_tvalid & bus.m_axis_tready;
  assign done = ~ser_q & pop & bus.m_axis_tlast;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    mask_d  = mask_q;
    frame_d = frame_q;
    wait_d  = wait_q;
    ovf_d   = ovf_q;
    stclr_d = 1'b0;
    ser_d   = ser_q;
    rem_d   = rem_q;
    data_d  = data_q;
    lastf_d = lastf_q;

    if (push) begin
      rem_d = rem_nxt;
      if (rem_nxt == '0) begin
        ser_d = 1'b0;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          len_d   = sample_len;
          mask_d  = ch_mask;
          frame_d = '0;
          wait_d  = '0;
          ovf_d   = 1'b0;
          stclr_d = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_q == WLAST) begin
          state_d = SAMPLE;
        end else begin
          wait_d = wait_q + WC_W'(1);
        end
      end
      SAMPLE: begin
        if (drop) begin
          ovf_d = 1'b1;
        end
        if (accept) begin
          frame_d = frame_nxt;
          data_d  = bus.adc_data;
          rem_d   = mask_q;
          ser_d   = 1'b1;
          lastf_d = (frame_nxt == len_q);
          if (frame_nxt == len_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge adc_clk) begin
    if (!adc_rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      len_q   <= '0;
      mask_q  <= '0;
      frame_q <= '0;
      wait_q  <= '0;
      ovf_q   <= 1'b0;
      stclr_q <= 1'b0;
      ser_q   <= 1'b0;
      rem_q   <= '0;
      data_q  <= '0;
      lastf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= sample_start;
      len_q   <= len_d;
      mask_q  <= mask_d;
      frame_q <= frame_d;
      wait_q  <= wait_d;
      ovf_q   <= ovf_d;
      stclr_q <= stclr_d;
      ser_q   <= ser_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      lastf_q <= lastf_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (adc_clk),
    .rst_n   (adc_rst_n),
    .push_i  (push),
    .din_i   ({lastf_q & (rem_nxt == '0), sel_word}),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .dout_o  (fifo_dout)
  );

  // Mask the unreset FIFO storage so an idle stream reads as zero.
  assign bus.m_axis_tvalid = ~fifo_empty;
  assign bus.m_axis_tdata  = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];
  assign bus.m_axis_tlast  = ~fifo_empty & fifo_dout[DATA_W];
  assign bus.m_axis_tkeep  = '1;

  assign st_clr    = stclr_q;
  assign busy      = (state_q != IDLE);
  assign overflow  = ovf_q;
  assign sample_en = (state_q == SAMPLE);

endmodule

// File: tb/tb_adc_stream_packer.sv
// Scoreboard bench for adc_stream_packer.
// Expected words are queued at frame drive time and popped on handshakes.
module tb_adc_stream_packer;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int DEP = 4;
  localparam int WC  = 6;
  localparam int LW  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           sample_start;
  logic [LW-1:0]  sample_len;
  logic [NCH-1:0] ch_mask;
  logic           st_clr;
  logic           busy;
  logic           overflow;
  logic           sample_en;

  adc_stream_packer_if #(.NUM_CH(NCH), .DATA_W(DW)) bus ();

  adc_stream_packer #(
    .NUM_CH      (NCH),
    .DATA_W      (DW),
    .FIFO_DEPTH  (DEP),
    .WAIT_CYCLES (WC),
    .LEN_W       (LW)
  ) dut (
    .adc_clk      (clk),
    .adc_rst_n    (rst_n),
    .sample_start (sample_start),
    .sample_len   (sample_len),
    .ch_mask      (ch_mask),
    .st_clr       (st_clr),
    .busy         (busy),
    .overflow     (overflow),
    .sample_en    (sample_en),
    .bus          (bus)
  );

  logic [DW:0]    exp_q [$];
  logic [DW:0]    e_word;
  logic [NCH-1:0] cur_mask;
  int n_cmp  = 0;
  int n_err  = 0;
  int n_pop  = 0;
  int cyc    = 0;
  int tl_cyc = -10;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.m_axis_tvalid && bus.m_axis_tready) begin
      if (exp_q.size() == 0) begin
        chk("extra_word", 64'(exp_q.size()), 64'd1);
      end else begin
        e_word = exp_q.pop_front();
        chk("word", 64'({bus.m_axis_tlast, bus.m_axis_tdata}),
            64'(e_word));
      end
      n_pop++;
      if (bus.m_axis_tlast) tl_cyc = cyc;
    end
  end

  function automatic logic [NCH*DW-1:0] rnd();
    return {$urandom(), $urandom()};
  endfunction

  task automatic push_frame(input logic [NCH*DW-1:0] d,
                            input bit lastf);
    int hi = 0;
    for (int i = 0; i < NCH; i++) if (cur_mask[i]) hi = i;
    for (int i = 0; i < NCH; i++) begin
      if (cur_mask[i]) begin
        exp_q.push_back({lastf && (i == hi), d[i*DW +: DW]});
      end
    end
  endtask

  task automatic send_frame(input logic [NCH*DW-1:0] d,
                            input bit acc,
                            input bit lastf);
    @(posedge clk); #1;
    bus.adc_valid = 1'b1;
    bus.adc_data  = d;
    if (acc) push_frame(d, lastf);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.adc_valid = 1'b0;
    end
  endtask

  task automatic start_cap(input logic [LW-1:0] len,
                           input logic [NCH-1:0] m);
    @(posedge clk); #1;
    sample_len   = len;
    ch_mask      = m;
    sample_start = 1'b1;
    cur_mask     = m;
    @(posedge clk); #1;
    sample_start = 1'b0;
    chk("st_clr", 64'(st_clr), 64'd1);
    chk("busy_on", 64'(busy), 64'd1);
    chk("ovf_clr", 64'(overflow), 64'd0);
    repeat (WC - 1) @(posedge clk);
    #1;
    chk("sen_early", 64'(sample_en), 64'd0);
    @(posedge clk); #1;
    chk("sen_on", 64'(sample_en), 64'd1);
    // Changing the inputs mid-capture must not disturb it.
    ch_mask    = ~m;
    sample_len = 7;
  endtask

  task automatic ignored_start(input logic [LW-1:0] len,
                               input logic [NCH-1:0] m,
                               input string tag);
    logic seen_clr = 1'b0;
    logic seen_bsy = 1'b0;
    @(posedge clk); #1;
    sample_len   = len;
    ch_mask      = m;
    sample_start = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      sample_start = 1'b0;
      seen_clr = seen_clr | st_clr;
      seen_bsy = seen_bsy | busy;
    end
    chk({tag, "_clr"}, 64'(seen_clr), 64'd0);
    chk({tag, "_busy"}, 64'(seen_bsy), 64'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle", 64'(busy), 64'd0);
    chk("busy_fall", 64'(cyc), 64'(tl_cyc + 1));
    chk("sb_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] head;
    int n;
    rst_n             = 1'b0;
    sample_start      = 1'b0;
    sample_len        = '0;
    ch_mask           = '0;
    cur_mask          = '0;
    bus.adc_valid     = 1'b0;
    bus.adc_data      = '0;
    bus.m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_st_clr", 64'(st_clr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_sen", 64'(sample_en), 64'd0);
    chk("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(bus.m_axis_tlast), 64'd0);
    chk("rst_tdata", 64'(bus.m_axis_tdata), 64'd0);
    rst_n = 1'b1;

    ignored_start(0, 4'hF, "len0");
    ignored_start(3, 4'h0, "mask0");

    // Full mask, three frames, latency checks on the first.
    start_cap(3, 4'hF);
    send_frame(rnd(), 1'b1, 1'b0);
    @(posedge clk); #1;
    bus.adc_valid = 1'b0;
    chk("lat_f1", 64'(bus.m_axis_tvalid), 64'd0);
    @(posedge clk); #1;
    chk("lat_f2", 64'(bus.m_axis_tvalid), 64'd1);
    chk("tkeep", 64'(bus.m_axis_tkeep), 64'h3);
    idle(4);
    send_frame(rnd(), 1'b1, 1'b0);
    idle(6);
    send_frame(rnd(), 1'b1, 1'b1);
    idle(1);
    chk("sen_off", 64'(sample_en), 64'd0);
    wait_idle();
    chk("t1_ovf", 64'(overflow), 64'd0);

    // Sparse mask 1010: only channels 1 and 3.
    start_cap(2, 4'b1010);
    send_frame(rnd(), 1'b1, 1'b0);
    idle(6);
    send_frame(rnd(), 1'b1, 1'b1);
    idle(1);
    wait_idle();

    // Back-to-back strobes: second one is dropped.
    start_cap(2, 4'hF);
    send_frame(rnd(), 1'b1, 1'b0);
    send_frame(rnd(), 1'b0, 1'b0);
    idle(1);
    chk("ovf_set", 64'(overflow), 64'd1);
    idle(6);
    send_frame(rnd(), 1'b1, 1'b1);
    idle(1);
    wait_idle();
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Backpressure with a 4-deep FIFO.
    bus.m_axis_tready = 1'b0;
    start_cap(2, 4'hF);
    send_frame(rnd(), 1'b1, 1'b0);
    idle(6);
    send_frame(rnd(), 1'b1, 1'b1);
    idle(1);
    for (int k = 0; k < 4; k++) begin
      repeat (10) @(posedge clk);
      #1;
      head = exp_q[0][DW-1:0];
      chk("stall_valid", 64'(bus.m_axis_tvalid), 64'd1);
      chk("stall_data", 64'(bus.m_axis_tdata), 64'(head));
      chk("stall_busy", 64'(busy), 64'd1);
    end
    bus.m_axis_tready = 1'b1;
    wait_idle();
    chk("t4_ovf", 64'(overflow), 64'd0);

    // Reset in the middle of a capture after five words.
    start_cap(3, 4'hF);
    n_pop = 0;
    send_frame(rnd(), 1'b1, 1'b0);
    idle(6);
    send_frame(rnd(), 1'b1, 1'b0);
    n = 0;
    while (n_pop < 5 && n < 50) begin
      @(posedge clk); #1;
      bus.adc_valid = 1'b0;
      n++;
    end
    chk("rst_reach", 64'(n_pop), 64'd5);
    bus.m_axis_tready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_sen", 64'(sample_en), 64'd0);
    rst_n = 1'b1;
    exp_q.delete();
    bus.m_axis_tready = 1'b1;

    // Clean capture after the reset.
    start_cap(2, 4'b0110);
    send_frame(rnd(), 1'b1, 1'b0);
    idle(6);
    send_frame(rnd(), 1'b1, 1'b1);
    idle(1);
    wait_idle();
    chk("t6_ovf", 64'(overflow), 64'd0);

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
